// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// datapath mux selects and fault codes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC_R   = 4'd7,
      S_R_WB     = 4'd8,
      S_EXEC_I   = 4'd9,
      S_I_WB     = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_AND   = 2'b11;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [1:0] DST_RT  = 2'b00;
   localparam logic [1:0] DST_RD  = 2'b01;
   localparam logic [1:0] DST_R31 = 2'b10;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_PC     = 2'b10;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

   // States that hold a memory strobe and wait on mem_ready.
   function automatic logic is_mem_wait(state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating count of consecutive mem_ready-low cycles in one memory access;
// flags expiry on the last permitted wait cycle.
module mc_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] MAX   = CW'(MEM_TIMEOUT);
   localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] wait_cnt;

   // NOTE: non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wait_cnt <= '0;
      else if (clear)
         wait_cnt <= '0;
      else if (count && (wait_cnt != MAX))
         wait_cnt <= wait_cnt + CW'(1);
   end

   assign expired = (MEM_TIMEOUT != 0) && count && (wait_cnt == LIMIT);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared datapath, with a ready handshake and memory timeout.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter bit SUPPORT_JAL = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       reg_write,
   output logic       instr_done,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic [3:0] state
);

   state_t     state_q, next_state;
   logic [1:0] trap_code;
   logic       fault_q;
   logic [1:0] fault_code_q;
   logic       timer_clear, timer_count, timer_expired;

   assign timer_count = is_mem_wait(state_q) && !mem_ready;
   assign timer_clear = is_mem_wait(next_state) && (next_state != state_q);

   mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear),
      .count   (timer_count),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         fault_q      <= 1'b0;
         fault_code_q <= FAULT_NONE;
      end else begin
         state_q <= next_state;
         if (next_state == S_TRAP && state_q != S_TRAP) begin
            fault_q      <= 1'b1;
            fault_code_q <= trap_code;
         end
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no branch can infer a latch.
      next_state = state_q;
      trap_code  = FAULT_NONE;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_ALU;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_op     = ALU_ADD;
      reg_dst    = DST_RT;
      mem_to_reg = WB_ALUOUT;
      reg_write  = 1'b0;
      instr_done = 1'b0;

      case (state_q)
         S_IDLE: next_state = S_FETCH;

         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               next_state = S_DECODE;
            end else if (timer_expired) begin
               next_state = S_TRAP;
               trap_code  = FAULT_TIMEOUT;
            end
         end

         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            case (opcode)
               OP_LW, OP_SW:     next_state = S_MEM_ADDR;
               OP_RTYPE:         next_state = S_EXEC_R;
               OP_ADDI, OP_ANDI: next_state = S_EXEC_I;
               OP_BEQ, OP_BNE:   next_state = S_BRANCH;
               OP_J:             next_state = S_JUMP;
               OP_JAL: begin
                  if (SUPPORT_JAL) begin
                     next_state = S_JUMP;
                  end else begin
                     next_state = S_TRAP;
                     trap_code  = FAULT_ILLEGAL;
                  end
               end
               default: begin
                  next_state = S_TRAP;
                  trap_code  = FAULT_ILLEGAL;
               end
            endcase
         end

         S_MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end

         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) begin
               next_state = S_MEM_WB;
            end else if (timer_expired) begin
               next_state = S_TRAP;
               trap_code  = FAULT_TIMEOUT;
            end
         end

         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = WB_MDR;
            instr_done = 1'b1;
            next_state = S_FETCH;
         end

         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               next_state = S_FETCH;
            end else if (timer_expired) begin
               next_state = S_TRAP;
               trap_code  = FAULT_TIMEOUT;
            end
         end

         S_EXEC_R: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_FUNCT;
            next_state = S_R_WB;
         end

         S_R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = DST_RD;
            instr_done = 1'b1;
            next_state = S_FETCH;
         end

         S_EXEC_I: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            alu_op     = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
            next_state = S_I_WB;
         end

         S_I_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            next_state = S_FETCH;
         end

         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_SUB;
            pc_src     = PC_ALUOUT;
            pc_write   = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
            instr_done = 1'b1;
            next_state = S_FETCH;
         end

         S_JUMP: begin
            pc_write   = 1'b1;
            pc_src     = PC_JUMP;
            instr_done = 1'b1;
            // PC already holds PC+4 here, so it is the link value for jal.
            if (SUPPORT_JAL && (opcode == OP_JAL)) begin
               reg_write  = 1'b1;
               reg_dst    = DST_R31;
               mem_to_reg = WB_PC;
            end
            next_state = S_FETCH;
         end

         S_TRAP: next_state = S_TRAP;

         default: next_state = S_IDLE;
      endcase
   end

   assign fault      = fault_q;
   assign fault_code = fault_code_q;
   assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected control vectors are
// queued as stimulus is driven and compared on the falling edge.
module tb_mc_control_fsm;
   import mc_ctrl_pkg::*;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       instr_done;
      logic       fault;
      logic [1:0] fault_code;
      logic [3:0] state;
   } obs_t;

   typedef struct packed {
      logic [5:0] op;
      logic       z;
      logic       rdy;
      obs_t       exp;
   } stim_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;

   logic       mem_read, mem_write, iord, ir_write, pc_write;
   logic [1:0] pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg, fault_code;
   logic       alu_src_a, reg_write, instr_done, fault;
   logic [3:0] state;

   logic       n_mem_read, n_mem_write, n_iord, n_ir_write, n_pc_write;
   logic [1:0] n_pc_src, n_alu_src_b, n_alu_op, n_reg_dst, n_mem_to_reg, n_fault_code;
   logic       n_alu_src_a, n_reg_write, n_instr_done, n_fault;
   logic [3:0] n_state;

   int n_checks = 0;
   int n_errors = 0;
   int mon_cyc  = 0;

   stim_t stim_q[$];
   obs_t  exp_q[$];
   int    done_q[$];
   obs_t  obs, n_obs, mon_e;

   always #5 clk = ~clk;

   mc_control_fsm #(.MEM_TIMEOUT(8), .SUPPORT_JAL(1'b1)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .instr_done(instr_done), .fault(fault), .fault_code(fault_code), .state(state)
   );

   mc_control_fsm #(.MEM_TIMEOUT(8), .SUPPORT_JAL(1'b0)) dut_nojal (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_read(n_mem_read), .mem_write(n_mem_write), .iord(n_iord), .ir_write(n_ir_write),
      .pc_write(n_pc_write), .pc_src(n_pc_src), .alu_src_a(n_alu_src_a),
      .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .reg_dst(n_reg_dst),
      .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write), .instr_done(n_instr_done),
      .fault(n_fault), .fault_code(n_fault_code), .state(n_state)
   );

   assign obs = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                 alu_op, reg_dst, mem_to_reg, reg_write, instr_done, fault, fault_code, state};
   assign n_obs = {n_mem_read, n_mem_write, n_iord, n_ir_write, n_pc_write, n_pc_src,
                   n_alu_src_a, n_alu_src_b, n_alu_op, n_reg_dst, n_mem_to_reg, n_reg_write,
                   n_instr_done, n_fault, n_fault_code, n_state};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Expected control vectors, written straight from the state descriptions.
   function automatic obs_t base(state_t s);
      obs_t e;
      e = '0;
      e.state = s;
      return e;
   endfunction

   function automatic obs_t e_fetch(logic rdy);
      obs_t e = base(S_FETCH);
      e.mem_read = 1'b1; e.alu_src_b = 2'b01;
      e.ir_write = rdy;  e.pc_write  = rdy;
      return e;
   endfunction

   function automatic obs_t e_decode();
      obs_t e = base(S_DECODE);
      e.alu_src_b = 2'b11;
      return e;
   endfunction

   function automatic obs_t e_mem_addr();
      obs_t e = base(S_MEM_ADDR);
      e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
      return e;
   endfunction

   function automatic obs_t e_mem_rd();
      obs_t e = base(S_MEM_RD);
      e.mem_read = 1'b1; e.iord = 1'b1;
      return e;
   endfunction

   function automatic obs_t e_mem_wb();
      obs_t e = base(S_MEM_WB);
      e.reg_write = 1'b1; e.mem_to_reg = 2'b01; e.instr_done = 1'b1;
      return e;
   endfunction

   function automatic obs_t e_mem_wr(logic rdy);
      obs_t e = base(S_MEM_WR);
      e.mem_write = 1'b1; e.iord = 1'b1; e.instr_done = rdy;
      return e;
   endfunction

   function automatic obs_t e_exec(logic is_i, logic is_andi);
      obs_t e = base(is_i ? S_EXEC_I : S_EXEC_R);
      e.alu_src_a = 1'b1;
      e.alu_src_b = is_i ? 2'b10 : 2'b00;
      e.alu_op    = is_i ? (is_andi ? 2'b11 : 2'b00) : 2'b10;
      return e;
   endfunction

   function automatic obs_t e_wb(logic is_i);
      obs_t e = base(is_i ? S_I_WB : S_R_WB);
      e.reg_write = 1'b1; e.instr_done = 1'b1;
      e.reg_dst = is_i ? 2'b00 : 2'b01;
      return e;
   endfunction

   function automatic obs_t e_branch(logic pcw);
      obs_t e = base(S_BRANCH);
      e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01;
      e.pc_write = pcw;   e.instr_done = 1'b1;
      return e;
   endfunction

   function automatic obs_t e_jump(logic link);
      obs_t e = base(S_JUMP);
      e.pc_write = 1'b1; e.pc_src = 2'b10; e.instr_done = 1'b1;
      if (link) begin
         e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
      end
      return e;
   endfunction

   function automatic obs_t e_trap(logic [1:0] code);
      obs_t e = base(S_TRAP);
      e.fault = 1'b1; e.fault_code = code;
      return e;
   endfunction

   task automatic add(input logic [5:0] op, input logic z, input logic rdy, input obs_t e);
      stim_t s;
      s.op = op; s.z = z; s.rdy = rdy; s.exp = e;
      stim_q.push_back(s);
   endtask

   // mem_ready and zero are randomised where the state must ignore them.
   task automatic add_any(input logic [5:0] op, input obs_t e);
      add(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
   endtask

   task automatic push_lw(input int waits);
      add(OP_LW, 1'b0, 1'b1, e_fetch(1'b1));
      add_any(OP_LW, e_decode());
      add_any(OP_LW, e_mem_addr());
      for (int i = 0; i < waits; i++) add(OP_LW, 1'b0, 1'b0, e_mem_rd());
      add(OP_LW, 1'b0, 1'b1, e_mem_rd());
      add_any(OP_LW, e_mem_wb());
   endtask

   task automatic push_alu(input logic [5:0] op);
      logic is_i;
      is_i = (op != OP_RTYPE);
      add(op, 1'b0, 1'b1, e_fetch(1'b1));
      add_any(op, e_decode());
      add_any(op, e_exec(is_i, op == OP_ANDI));
      add_any(op, e_wb(is_i));
   endtask

   task automatic push_br(input logic is_bne, input logic z);
      logic [5:0] op;
      op = is_bne ? OP_BNE : OP_BEQ;
      add(op, 1'b0, 1'b1, e_fetch(1'b1));
      add_any(op, e_decode());
      add(op, z, 1'($urandom_range(0, 1)), e_branch(is_bne ? !z : z));
   endtask

   task automatic push_j(input logic link);
      logic [5:0] op;
      op = link ? OP_JAL : OP_J;
      add(op, 1'b0, 1'b1, e_fetch(1'b1));
      add_any(op, e_decode());
      add_any(op, e_jump(link));
   endtask

   task automatic run();
      stim_t s;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         opcode = s.op; zero = s.z; mem_ready = s.rdy;
         exp_q.push_back(s.exp);
         @(posedge clk);
         #1;
      end
   endtask

   // Holds reset over an edge with active-looking inputs, then releases it and
   // queues the IDLE cycle that precedes the first FETCH.
   task automatic do_reset();
      reset = 1'b1; opcode = OP_LW; zero = 1'b1; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      check("reset_outputs", obs, base(S_IDLE));
      check("reset_outputs_nojal", n_obs, base(S_IDLE));
      @(posedge clk);
      #1;
      reset = 1'b0;
      add_any(OP_RTYPE, base(S_IDLE));
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_cyc++;
         check($sformatf("cyc%0d_state%0d", mon_cyc, mon_e.state), obs, mon_e);
         if (instr_done) done_q.push_back(mon_cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int first_fetch, n0, last_j;
      int want_done[5] = '{4, 9, 13, 16, 19};

      // Zero-wait sequence: R-type, lw, sw, beq taken, j.
      do_reset();
      first_fetch = mon_cyc + 2;
      n0 = done_q.size();
      push_alu(OP_RTYPE);
      push_lw(0);
      add(OP_SW, 1'b0, 1'b1, e_fetch(1'b1));
      add_any(OP_SW, e_decode());
      add_any(OP_SW, e_mem_addr());
      add(OP_SW, 1'b0, 1'b1, e_mem_wr(1'b1));
      push_br(1'b0, 1'b1);
      push_j(1'b0);
      run();
      check("done_count", done_q.size() - n0, 5);
      for (int i = 0; i < 5; i++)
         if (done_q.size() > n0 + i)
            check($sformatf("done_cycle_%0d", i), done_q[n0 + i] - first_fetch + 1, want_done[i]);

      // lw with three wait cycles, addi, andi, then bne not-taken and taken.
      last_j = done_q[done_q.size() - 1];
      push_lw(3);
      push_alu(OP_ADDI);
      push_alu(OP_ANDI);
      push_br(1'b1, 1'b1);
      push_br(1'b1, 1'b0);
      run();
      check("lw_wait_length", done_q[done_q.size() - 5] - last_j, 8);

      // jal: linked jump when supported, illegal opcode when not.
      do_reset();
      push_j(1'b1);
      run();
      check("nojal_state", n_state, S_TRAP);
      check("nojal_fault", n_fault, 1);
      check("nojal_fault_code", n_fault_code, 2'b01);

      // Undefined opcode traps and stays trapped.
      add(6'h3F, 1'b0, 1'b1, e_fetch(1'b1));
      add_any(6'h3F, e_decode());
      for (int i = 0; i < 3; i++) add_any(6'h3F, e_trap(2'b01));
      run();

      // Fetch timeout: eight low cycles trap.
      do_reset();
      for (int i = 0; i < 8; i++) add(OP_RTYPE, 1'b0, 1'b0, e_fetch(1'b0));
      for (int i = 0; i < 2; i++) add_any(OP_RTYPE, e_trap(2'b10));
      run();

      // Ready on the eighth cycle completes the fetch normally.
      do_reset();
      for (int i = 0; i < 7; i++) add(OP_RTYPE, 1'b0, 1'b0, e_fetch(1'b0));
      add(OP_RTYPE, 1'b0, 1'b1, e_fetch(1'b1));
      add_any(OP_RTYPE, e_decode());
      add_any(OP_RTYPE, e_exec(1'b0, 1'b0));
      add_any(OP_RTYPE, e_wb(1'b0));
      run();

      // Reset asserted while a store is waiting on memory.
      add(OP_SW, 1'b0, 1'b1, e_fetch(1'b1));
      add_any(OP_SW, e_decode());
      add_any(OP_SW, e_mem_addr());
      add(OP_SW, 1'b0, 1'b0, e_mem_wr(1'b0));
      add(OP_SW, 1'b0, 1'b0, e_mem_wr(1'b0));
      run();
      mem_ready = 1'b0;
      check("wr_before_reset", mem_write, 1);
      #2;
      reset = 1'b1;
      #1;
      check("wr_after_reset", mem_write, 0);
      check("state_after_reset", state, S_IDLE);
      do_reset();
      push_alu(OP_RTYPE);
      run();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
